// File: rtl/ifu_if.sv
// Instruction-memory request/acknowledge port between the fetch unit and instruction memory.
// master = fetch unit (drives request/address), slave = memory (returns ack/data).
interface ifu_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifu.sv
// MIPS instruction fetch: holds PC, fetches one word per retirement, computes next PC from NPCSel.
// Latency: request one cycle after reset/commit, instr_valid on the ack edge; req held until ack.
// Optional IFU_MISALIGN_CHECK_EN: misaligned next PC halts the unit and sets sticky misalign_err.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  NPCSel,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] reg_target,
    input  logic        commit,
    ifu_if.master       imem,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] npc_raw;
    logic [31:0] npc;
    logic        npc_misaligned;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc_raw = pc4;
        case (NPCSel)
            2'b00:   npc_raw = pc4;
            2'b01:   npc_raw = pc4 + br_off;
            2'b10:   npc_raw = {pc4[31:28], target26, 2'b00};
            default: npc_raw = reg_target;
        endcase
    end

`ifdef IFU_MISALIGN_CHECK_EN
    assign npc            = npc_raw;
    assign npc_misaligned = |npc_raw[1:0];
`else
    // Without the check a register target is silently truncated to a word boundary.
    assign npc            = npc_raw & ~32'd3;
    assign npc_misaligned = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (commit) begin
                    pc_d          = npc;
                    instr_valid_d = 1'b0;
                    state_d       = npc_misaligned ? HALT : FETCH;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic enter_halt;

    assign enter_halt = (state_q == HOLD) && commit && npc_misaligned;
    assign misalign_d = misalign_q | enter_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Request is decoded from state so an asynchronous reset drops it immediately.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];
    assign pc             = pc_q;
    assign pc_plus4       = pc4;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run against a next-PC model.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  npc_sel;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] reg_target;
    logic        commit;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_if u_if ();

    ifu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .NPCSel      (npc_sel),
        .imm16       (imm16),
        .target26    (target26),
        .reg_target  (reg_target),
        .commit      (commit),
        .imem        (u_if),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference next PC, from the architectural rules.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] sel,
                                            input logic [15:0] off, input logic [25:0] idx,
                                            input logic [31:0] rt);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (sel)
            2'd0:    return seq;
            2'd1:    return seq + 32'(int'($signed(off)) * 4);
            2'd2:    return (seq & 32'hF000_0000) | (32'(idx) << 2);
            default: return rt;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        commit = 1'b0;
        u_if.imem_ack = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a request, lets it wait 'delay' cycles, then acks with 'data'.
    task automatic do_fetch(input logic [31:0] data, input int delay, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !u_if.imem_req; i++) step();
        if (!u_if.imem_req) return;
        repeat (delay) step();
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = data;
        step();
        u_if.imem_ack   = 1'b0;
        u_if.imem_rdata = $urandom;
        ok = 1'b1;
    endtask

    // Fields are scrambled after the commit edge: they must only be sampled on it.
    task automatic do_commit(input logic [1:0] sel, input logic [15:0] imm,
                             input logic [25:0] tgt, input logic [31:0] rt);
        npc_sel = sel; imm16 = imm; target26 = tgt; reg_target = rt;
        commit = 1'b1;
        step();
        commit = 1'b0;
        npc_sel = 2'($urandom); imm16 = 16'($urandom);
        target26 = 26'($urandom); reg_target = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; commit = 1'b0; npc_sel = 2'd0; imm16 = 16'd0;
        target26 = 26'd0; reg_target = 32'd0;
        u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'd0;
        repeat (3) step();
        n_checks++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h3000); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", u_if.imem_req); end
        n_checks++; if (u_if.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr: got %h expected 3000", u_if.imem_addr); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", misalign_err); end
        n_checks++; if (pc_plus4 !== 32'h3004) begin n_fail++; $display("FAIL rst_pc4: got %h expected 3004", pc_plus4); end
        n_checks++; if (opcode !== 6'd0 || funct !== 6'd0) begin n_fail++; $display("FAIL rst_opfn: got %h/%h expected 0/0", opcode, funct); end
        rst_n = 1'b1;
        n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_idle: got %b expected 0", u_if.imem_req); end
        step();
        n_checks++; if (u_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", u_if.imem_req); end
        n_checks++; if (u_if.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL first_addr: got %h expected 3000", u_if.imem_addr); end
    endtask

    task automatic test_zero_wait();
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h3C01_1234;
        step();
        u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'hDEAD_BEEF;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h3C01_1234) begin n_fail++; $display("FAIL zw_instr: got %h expected 3c011234", instr); end
        n_checks++; if (opcode !== 6'h0F) begin n_fail++; $display("FAIL zw_opcode: got %h expected 0f", opcode); end
        n_checks++; if (funct !== 6'h34) begin n_fail++; $display("FAIL zw_funct: got %h expected 34", funct); end
        n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_req: got %b expected 0", u_if.imem_req); end
    endtask

    task automatic test_ack_delay();
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h3000 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL dly_wait%0d: got req=%b addr=%h valid=%b expected 1/3000/0", i, u_if.imem_req, u_if.imem_addr, instr_valid);
            end
            step();
        end
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h0000_0021;
        step();
        u_if.imem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h21) begin
            n_fail++; $display("FAIL dly_ack: got valid=%b instr=%h expected 1/00000021", instr_valid, instr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        do_commit(2'd0, 16'h0, 26'h0, 32'h0);
        do_fetch($urandom, 0, ok);
        n_checks++; if (!ok || pc !== 32'h3004) begin n_fail++; $display("FAIL br_setup: got ok=%b pc=%h expected 1/3004", ok, pc); end
        do_commit(2'd1, 16'hFFFE, 26'h0, 32'h0);
        n_checks++; if (u_if.imem_addr !== 32'h3000 || u_if.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL br_back: got addr=%h req=%b expected 3000/1", u_if.imem_addr, u_if.imem_req);
        end
        do_fetch($urandom, 1, ok);
        do_commit(2'd0, 16'h0, 26'h0, 32'h0);
        do_fetch($urandom, 0, ok);
        do_commit(2'd1, 16'h0003, 26'h0, 32'h0);
        n_checks++; if (!ok || u_if.imem_addr !== 32'h3014) begin n_fail++; $display("FAIL br_fwd: got addr=%h expected 3014", u_if.imem_addr); end
    endtask

    task automatic test_jump();
        bit ok;
        do_fetch($urandom, 0, ok);
        do_commit(2'd3, 16'h0, 26'h0, 32'h3008);
        do_fetch($urandom, 0, ok);
        do_commit(2'd2, 16'h0, 26'h000_0C10, 32'h0);
        n_checks++; if (!ok || pc !== 32'h3040) begin n_fail++; $display("FAIL jmp_j: got pc=%h expected 3040", pc); end
        do_fetch($urandom, 0, ok);
        do_commit(2'd3, 16'h0, 26'h0, 32'h3100);
        n_checks++; if (!ok || pc !== 32'h3100) begin n_fail++; $display("FAIL jmp_jr: got pc=%h expected 3100", pc); end
    endtask

    task automatic test_misalign();
        bit ok;
        do_fetch($urandom, 0, ok);
        do_commit(2'd3, 16'h0, 26'h0, 32'h3102);
`ifdef IFU_MISALIGN_CHECK_EN
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
        for (int i = 0; i < 4; i++) begin
            u_if.imem_ack = i[0]; commit = ~i[0];
            step();
            n_checks++; if (u_if.imem_req !== 1'b0 || misalign_err !== 1'b1) begin
                n_fail++; $display("FAIL mis_halt%0d: got req=%b err=%b expected 0/1", i, u_if.imem_req, misalign_err);
            end
        end
        u_if.imem_ack = 1'b0; commit = 1'b0;
`else
        n_checks++; if (misalign_err !== 1'b0 || pc !== 32'h3100 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h3100) begin
            n_fail++; $display("FAIL mis_trunc: got err=%b pc=%h req=%b addr=%h expected 0/3100/1/3100", misalign_err, pc, u_if.imem_req, u_if.imem_addr);
        end
`endif
    endtask

    task automatic test_ignored();
        do_reset();
        step();
        npc_sel = 2'd3; reg_target = 32'h4000; commit = 1'b1;
        step();
        commit = 1'b0;
        n_checks++; if (pc !== 32'h3000 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h3000) begin
            n_fail++; $display("FAIL ign_commit: got pc=%h req=%b addr=%h expected 3000/1/3000", pc, u_if.imem_req, u_if.imem_addr);
        end
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'hAAAA_0001;
        step();
        u_if.imem_rdata = 32'hBBBB_0002;
        step();
        u_if.imem_ack = 1'b0;
        n_checks++; if (instr !== 32'hAAAA_0001 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL ign_ack: got instr=%h valid=%b expected aaaa0001/1", instr, instr_valid);
        end
        do_commit(2'd0, 16'h0, 26'h0, 32'h0);
        n_checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h3004) begin
            n_fail++; $display("FAIL ign_fetch: got req=%b addr=%h expected 1/3004", u_if.imem_req, u_if.imem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", u_if.imem_req); end
        @(negedge clk);
        u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'hCCCC_0003;
        step();
        u_if.imem_ack = 1'b0;
        rst_n = 1'b1;
        n_checks++; if (pc !== 32'h3000 || instr !== 32'd0 || instr_valid !== 1'b0 || u_if.imem_req !== 1'b0 || pc_plus4 !== 32'h3004) begin
            n_fail++; $display("FAIL midrst_vals: got pc=%h instr=%h valid=%b req=%b pc4=%h expected 3000/0/0/0/3004", pc, instr, instr_valid, u_if.imem_req, pc_plus4);
        end
        step();
        step();
        n_checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h3000 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_refetch: got req=%b addr=%h valid=%b expected 1/3000/0", u_if.imem_req, u_if.imem_addr, instr_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_fetch($urandom, 0, ok);
        do_commit(2'd3, 16'h0, 26'h0, 32'hFFFF_FFFC);
        do_fetch($urandom, 0, ok);
        n_checks++; if (!ok || pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", pc_plus4); end
        do_commit(2'd0, 16'h0, 26'h0, 32'h0);
        n_checks++; if (pc !== 32'd0 || u_if.imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_pc: got pc=%h addr=%h expected 0/0", pc, u_if.imem_addr); end
    endtask

    task automatic test_random();
        bit          ok;
        logic [31:0] exp_pc, data, rt;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [25:0] tgt;
        do_reset();
        exp_pc = 32'h3000;
        for (int n = 0; n < 150; n++) begin
            data = $urandom;
            do_fetch(data, $urandom_range(0, 3), ok);
            n_checks++; if (!ok || instr !== data || instr_valid !== 1'b1) begin
                n_fail++; $display("FAIL rnd_instr%0d: got ok=%b instr=%h valid=%b expected 1/%h/1", n, ok, instr, instr_valid, data);
            end
            n_checks++; if (opcode !== data[31:26] || funct !== data[5:0] || pc_plus4 !== exp_pc + 32'd4) begin
                n_fail++; $display("FAIL rnd_dec%0d: got op=%h fn=%h pc4=%h expected %h/%h/%h", n, opcode, funct, pc_plus4, data[31:26], data[5:0], exp_pc + 32'd4);
            end
            repeat ($urandom_range(0, 2)) begin
                u_if.imem_ack = 1'($urandom); u_if.imem_rdata = $urandom;
                step();
            end
            u_if.imem_ack = 1'b0;
            n_checks++; if (instr !== data) begin n_fail++; $display("FAIL rnd_hold%0d: got %h expected %h", n, instr, data); end
            sel = 2'($urandom); imm = 16'($urandom); tgt = 26'($urandom);
            rt  = $urandom & ~32'd3;
            exp_pc = ref_npc(exp_pc, sel, imm, tgt, rt);
            do_commit(sel, imm, tgt, rt);
            n_checks++; if (pc !== exp_pc || u_if.imem_addr !== exp_pc || u_if.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL rnd_npc%0d: got pc=%h addr=%h req=%b valid=%b expected %h/%h/1/0", n, pc, u_if.imem_addr, u_if.imem_req, instr_valid, exp_pc, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_branch();
        test_jump();
        test_misalign();
        test_ignored();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core. It holds the architectural PC, fetches one instruction word per retirement over a request/acknowledge instruction-memory port, and latches it in an instruction register. It presents `opcode`/`funct` to the controller and computes the next PC from the controller's `NPCSel` when the datapath commits. It sits directly upstream of the controller and consumes its `NPCSel` output.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset; must be word-aligned.
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `NPCSel`  in  2  next-PC select: 00 PC+4, 01 branch (BEQ taken), 10 J/JAL target, 11 register (JR).
- `imm16`  in  16  branch offset (instr[15:0]).
- `target26`  in  26  jump index (instr[25:0]).
- `reg_target`  in  32  JR target (rs value).
- `commit`  in  1  datapath retires current instruction this cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched word.
- `instr`  out  32  instruction register.
- `instr_valid`  out  1  `instr` holds the instruction at `pc`.
- `opcode`, `funct`  out  6 each  `instr[31:26]`, `instr[5:0]`.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4` (JAL link value).
- `misalign_err`  out  1  sticky: computed next PC not word-aligned.

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset state IDLE.
- IDLE: unconditionally -> FETCH next edge; `imem_req` rises.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, both stable until ack. On edge with `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, -> HOLD.
- HOLD: `instr` frozen. On edge with `commit`=1: `pc`<=npc, `instr_valid`<=0; if npc[1:0]==0 -> FETCH (`imem_req`<=1), else -> HALT, `misalign_err`<=1.
- HALT: no requests, all outputs frozen; exit only via reset.
- npc by `NPCSel`: 00 `pc+4`; 01 `pc+4 + {{14{imm16[15]}},imm16,2'b00}`; 10 `{pc_plus4[31:28],target26,2'b00}`; 11 `reg_target`. All additions 32-bit, wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- `commit` outside HOLD ignored. `imem_ack` outside FETCH ignored (stale data discarded).
- `pc_plus4`, `opcode`, `funct` combinational from registers.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `misalign_err`=0, `pc_plus4`=`RESET_PC`+4, `opcode`=`funct`=0.
- First `imem_req` high one cycle after reset deassertion edge.
- `imem_ack` may assert in the first request cycle; zero-wait memory gives `instr_valid` one cycle after `imem_req` rises.
- Minimum throughput: one instruction per 2 cycles (FETCH, HOLD), back-to-back with commit in first HOLD cycle.
- `NPCSel`, `imm16`, `target26`, `reg_target` sampled only on the commit edge.
- Reset asserted mid-FETCH: `imem_req` drops immediately (asynchronous); any later ack ignored until new FETCH.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: behaviour as above (misaligned npc -> HALT, `misalign_err` set).
- Not defined: npc[1:0] forced to 00, HALT state never entered, `misalign_err` tied 0.

## Test plan
- Reset, zero-wait memory returning 0x3C01_1234 at 0x3000 -> `imem_req` high cycle 1, `instr`=0x3C01_1234, `opcode`=0x0F, `instr_valid` high cycle 2.
- Memory ack delayed 3 cycles -> `imem_addr` stays 0x3000, `imem_req` held high, `instr_valid` low until ack edge.
- `pc`=0x3004, commit with `NPCSel`=01, `imm16`=0xFFFE -> next `imem_addr`=0x3000; `imm16`=0x0003 -> 0x3014.
- `pc`=0x3008, commit with `NPCSel`=10, `target26`=0x000_0C10 -> `pc`=0x0000_3040; `NPCSel`=11, `reg_target`=0x0000_3100 -> `pc`=0x3100.
- Commit `NPCSel`=11, `reg_target`=0x3102 -> with macro: HALT, `misalign_err`=1, no further `imem_req`; without: fetch at 0x3100.
- Commit and ack pulses during FETCH/HOLD respectively, plus reset mid-FETCH -> ignored; after reset `pc`=0x3000, outputs at reset values.
